mux4x1_rr_arbiter: RTL and testbench
====================================

MUX4X1_RR_ARBITER -- requirements
Module: mux4x1_rr_arbiter

Interface
- REQ-001: Parameter W, default 8: width of each requester data word and of output y.
- REQ-002: Parameter MAX_BURST, default 4: maximum consecutive cycles one owner holds the mux while another request is pending; legal range 1..15.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous, active-low.
- REQ-005: req  input  4  request per requester, bit k = requester k; level-sensitive.
- REQ-006: i0, i1, i2, i3  input  W each  data of requester 0..3.
- REQ-007: gnt  output  4  one-hot grant, registered; all-zero when idle.
- REQ-008: s1, s0  output  1 each  registered mux select, {s1,s0} = index of current owner.
- REQ-009: y  output  W  registered muxed data.
- REQ-010: vld  output  1  registered, high when y carries owner data.

Function
- REQ-011: Two-state FSM, IDLE and GRANT; owner index own[1:0], last-owner pointer ptr[1:0], burst counter cnt[3:0].
- REQ-012: IDLE: if req != 0 at an edge, go to GRANT with own = first set bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4); cnt = 0; otherwise stay in IDLE.
- REQ-013: GRANT, owner still requesting, no other request: stay; cnt saturates at MAX_BURST-1; no rotation.
- REQ-014: GRANT, owner still requesting, another request pending, cnt < MAX_BURST-1: stay, cnt increments.
- REQ-015: GRANT, owner still requesting, another request pending, cnt == MAX_BURST-1: rotate; ptr = own; new owner = first set bit of req searching own+1..own+3; cnt = 0.
- REQ-016: GRANT, req[own] == 0: ptr = own; if any other req set, new owner selected as in REQ-015 in the same edge (no idle bubble) with cnt = 0, else go to IDLE.
- REQ-017: gnt = one-hot(own) and {s1,s0} = own whenever state is GRANT; gnt = 0 and {s1,s0} hold their last value in IDLE.
- REQ-018: Data latency is one cycle after select: at every edge, y <= i[{s1,s0}] and vld <= (state == GRANT), using pre-edge register values.
- REQ-019: y holds its value when vld = 0.
- REQ-020: Exactly one gnt bit is high at any time in GRANT; a grant never goes to a requester whose req was low at the deciding edge.
- REQ-021: Every continuously asserted request is granted within 3*MAX_BURST+1 cycles.
- REQ-022: Request deasserted and reasserted in one cycle by the owner is treated as continuous only if sampled high at every edge.

Reset
- REQ-023: rst_n low asynchronously forces state = IDLE, gnt = 0, {s1,s0} = 0, y = 0, vld = 0, cnt = 0, ptr = 3, so requester 0 has first priority.
- REQ-024: Reset asserted during GRANT aborts the burst immediately; after release, arbitration restarts per REQ-012 with ptr = 3.
- REQ-025: First arbitration occurs at the first rising edge with rst_n high.

Verification
- REQ-026: After reset, req = 4'b1010 for 1 edge -> next cycle gnt = 4'b0010, {s1,s0} = 01; one cycle later vld = 1, y = i1.
- REQ-027: req = 4'b1111 held, MAX_BURST = 4 -> owners 0,1,2,3,0 each for exactly 4 cycles; gnt never zero; no overlap.
- REQ-028: Only req[2] held 20 cycles -> gnt = 4'b0100 continuously, cnt saturates, no rotation; then req[2] drops -> gnt = 0 next cycle, vld = 0 one cycle later.
- REQ-029: Owner 1 drops req while req[3] is high -> gnt switches 4'b0010 to 4'b1000 at the same edge, with no idle cycle.
- REQ-030: Owner 2 mid-burst (cnt = 2), rst_n pulsed low between edges -> gnt = 0, vld = 0, y = 0 immediately; after release with req = 4'b0101, first grant goes to requester 0.

Source files
------------

// File: rtl/mux4x1_rr_arbiter.sv
// Four-input data mux whose select is owned by a round-robin arbiter.
// An owner keeps the mux for up to MAX_BURST cycles while others wait.
module mux4x1_rr_arbiter #(
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  output logic [3:0]   gnt,
  output logic         s1,
  output logic         s0,
  output logic [W-1:0] y,
  output logic         vld
);

  localparam int unsigned CW      = 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [1:0]     own_q, own_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     gnt_q, gnt_d;
  logic [1:0]     sel_q, sel_d;
  logic [W-1:0]   y_q, y_d;
  logic           vld_q, vld_d;
  logic [3:0]     others;

  // First set bit of r searching base+1, base+2, base+3, base (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    logic [1:0] res;
    res = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    others  = req & ~(4'b0001 << own_q);

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          own_d   = pick(req, ptr_q);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[own_q]) begin
          ptr_d = own_q;
          cnt_d = '0;
          if (|others) own_d   = pick(others, own_q);
          else         state_d = IDLE;
        end else if (|others) begin
          if (cnt_q >= CNT_MAX) begin
            ptr_d = own_q;
            own_d = pick(others, own_q);
            cnt_d = '0;
          end else begin
            cnt_d = CW'(cnt_q + CW'(1));
          end
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = CW'(cnt_q + CW'(1));
        end
      end
      default: state_d = IDLE;
    endcase

    // Grant/select track the next owner; data lags select by one cycle.
    gnt_d = (state_d == GRANT) ? (4'b0001 << own_d) : 4'b0000;
    sel_d = (state_d == GRANT) ? own_d : sel_q;
    vld_d = (state_q == GRANT);
    y_d   = y_q;
    if (vld_d) begin
      case (sel_q)
        2'd0:    y_d = i0;
        2'd1:    y_d = i1;
        2'd2:    y_d = i2;
        default: y_d = i3;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      own_q   <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      y_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt = gnt_q;
  assign s1  = sel_q[1];
  assign s0  = sel_q[0];
  assign y   = y_q;
  assign vld = vld_q;

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Directed bench for mux4x1_rr_arbiter with hand-computed expected values.
module tb_mux4x1_rr_arbiter;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] i0, i1, i2, i3;
  logic [3:0]   gnt;
  logic         s1, s0;
  logic [W-1:0] y;
  logic         vld;

  int n_checks;
  int n_fail;

  mux4x1_rr_arbiter #(.W(W), .MAX_BURST(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .i0   (i0),
    .i1   (i1),
    .i2   (i2),
    .i3   (i3),
    .gnt  (gnt),
    .s1   (s1),
    .s0   (s0),
    .y    (y),
    .vld  (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    i0 = 8'hA0; i1 = 8'hB1; i2 = 8'hC2; i3 = 8'hD3;

    // reset values
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'({s1, s0}), 32'h0);
    check("rst_y",   32'(y), 32'h0);
    check("rst_vld", 32'(vld), 32'h0);

    // single edge request 1010 -> requester 1
    rst_n = 1'b1;
    req   = 4'b1010;
    step();
    check("first_gnt", 32'(gnt), 32'h2);
    check("first_sel", 32'({s1, s0}), 32'h1);
    check("first_vld", 32'(vld), 32'h0);
    req = 4'b0000;
    step();
    check("lat_gnt", 32'(gnt), 32'h0);
    check("lat_vld", 32'(vld), 32'h1);
    check("lat_y",   32'(y), 32'hB1);
    step();
    check("idle_vld", 32'(vld), 32'h0);
    check("idle_y",   32'(y), 32'hB1);

    // all requesting: owners 0,1,2,3,0 for four cycles each
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(4'b0001 << ((k / 4) % 4)));
      check($sformatf("rr_sel%0d", k), 32'({s1, s0}), 32'((k / 4) % 4));
    end

    // lone requester 2 held, then dropped
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      step();
      check($sformatf("solo_gnt%0d", k), 32'(gnt), 32'h4);
    end
    req = 4'b0000;
    step();
    check("drop_gnt", 32'(gnt), 32'h0);
    check("drop_vld", 32'(vld), 32'h1);
    check("drop_y",   32'(y), 32'hC2);
    step();
    check("drop_vld2", 32'(vld), 32'h0);
    check("drop_y2",   32'(y), 32'hC2);

    // saturated burst hands over on the first edge a competitor appears
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 6; k++) step();
    req = 4'b0101;
    step();
    check("sat_rot_gnt", 32'(gnt), 32'h1);

    // owner 1 releases while 3 waits: no idle bubble
    do_reset();
    req = 4'b0010;
    step();
    check("hand_gnt0", 32'(gnt), 32'h2);
    req = 4'b1010;
    step();
    check("hand_gnt1", 32'(gnt), 32'h2);
    req = 4'b1000;
    step();
    check("hand_gnt2", 32'(gnt), 32'h8);
    check("hand_sel",  32'({s1, s0}), 32'h3);
    check("hand_vld",  32'(vld), 32'h1);
    check("hand_y1",   32'(y), 32'hB1);
    step();
    check("hand_y2",   32'(y), 32'hD3);

    // asynchronous reset mid-burst
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 3; k++) step();
    check("mid_gnt", 32'(gnt), 32'h4);
    check("mid_y",   32'(y), 32'hC2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_vld", 32'(vld), 32'h0);
    check("arst_y",   32'(y), 32'h0);
    check("arst_sel", 32'({s1, s0}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0101;
    step();
    check("post_rst_gnt", 32'(gnt), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
